song_mem_ctrl: RTL and testbench

- Downstream consumer of the central FSM's song_choice / start_song / pause_song / record_mode / cfsm_state.
- Turns them into sample-rate memory transactions on the song sample memory:
  - playback: reads out a slot's stored samples;
  - record: writes incoming samples into a slot.
- Tracks the recorded length of every slot and returns song_done to the central FSM when a slot is exhausted or full.

---
 rtl/song_mem_pkg.sv | 7 +
 rtl/song_mem_ctrl_if.sv | 10 +
 rtl/song_len_table.sv | 30 +++
 rtl/song_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_song_mem_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/song_mem_pkg.sv
// song_mem_pkg: shared state encoding and slot constants for the song memory controller
package song_mem_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, REC, DONE} state_e;
    localparam int NUM_SLOTS = 16;
    localparam logic [3:0] RO_SLOT_LIMIT = 4'd8;
    localparam logic [1:0] CFSM_STANDBY = 2'b00;
endpackage

// File: rtl/song_mem_ctrl_if.sv
// song_mem_ctrl_if: sample memory bus between the controller (master) and the song memory (slave)
interface song_mem_ctrl_if #(parameter int ADDR_W = 19, parameter int DATA_W = 8);
    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    modport master (output addr, re, we, wdata, input rdata);
    modport slave (input addr, re, we, wdata, output rdata);
endinterface

// File: rtl/song_len_table.sv
// song_len_table: per-slot recorded length, preloaded slots full and user slots empty after reset
module song_len_table
    import song_mem_pkg::*;
#(
    parameter int SLOT_W = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [3:0]      waddr,
    input  logic [SLOT_W:0] wdata,
    input  logic [3:0]      raddr,
    output logic [SLOT_W:0] rdata
);
    localparam logic [SLOT_W:0] FULL = (SLOT_W+1)'(1) << SLOT_W;
    logic [SLOT_W:0] len_q [NUM_SLOTS];
    logic [SLOT_W:0] len_d [NUM_SLOTS];
    always_comb begin
        len_d = len_q;
        if (we) len_d[waddr] = wdata;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= (i < int'(RO_SLOT_LIMIT)) ? FULL : '0;
        end else begin
            len_q <= len_d;
        end
    end
    assign rdata = len_q[raddr];
endmodule

// File: rtl/song_mem_ctrl.sv
// song_mem_ctrl: turns central FSM play/record commands into sample-rate song memory transactions
module song_mem_ctrl
    import song_mem_pkg::*;
#(
    parameter int SLOT_W = 15,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        song_choice,
    input  logic              start_song,
    input  logic              pause_song,
    input  logic              record_mode,
    input  logic [1:0]        cfsm_state,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] rec_sample,
    song_mem_ctrl_if.master   mem,
    output logic [DATA_W-1:0] play_sample,
    output logic              play_valid,
    output logic              song_done,
    output logic              busy
);
    localparam int ADDR_W = 4 + SLOT_W;
    localparam logic [SLOT_W:0] ONE = (SLOT_W+1)'(1);
    localparam logic [SLOT_W:0] FULL = ONE << SLOT_W;
    localparam logic [SLOT_W:0] LAST = FULL - ONE;
    state_e            state_q, state_d;
    logic [3:0]        slot_q, slot_d;
    logic [SLOT_W:0]   offset_q, offset_d, off_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              re_q, re_d, we_q, we_d, done_q, done_d, busy_q, busy_d;
    logic [RD_LAT-1:0] re_pipe_q, re_pipe_d;
    logic              step, active, standby, commit_we;
    logic [SLOT_W:0]   commit_len, len_rd, len_new;
    logic [3:0]        len_idx;
    assign step    = sample_tick & ~pause_song;
    assign active  = state_q inside {PLAY, REC};
    assign standby = cfsm_state == CFSM_STANDBY;
    assign off_inc = offset_q + ONE;
    assign len_idx = start_song ? song_choice : slot_q;
    // A restart out of REC into the same slot must see the length being committed this cycle
    assign len_new = (state_q == REC && slot_q == song_choice) ? offset_q : len_rd;
    song_len_table #(.SLOT_W(SLOT_W)) u_len (
        .clk   (clk),
        .reset (reset),
        .we    (commit_we),
        .waddr (slot_q),
        .wdata (commit_len),
        .raddr (len_idx),
        .rdata (len_rd)
    );
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        offset_d   = offset_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        commit_we  = 1'b0;
        commit_len = offset_q;
        if (state_q == DONE) state_d = IDLE;
        if (active && step && !start_song) begin
            offset_d = off_inc;
            addr_d   = {slot_q, offset_q[SLOT_W-1:0]};
            re_d     = state_q == PLAY;
            we_d     = state_q == REC;
            wdata_d  = (state_q == REC) ? rec_sample : wdata_q;
            if (state_q == PLAY && off_inc == len_rd) state_d = DONE;
            if (state_q == REC && offset_q == LAST) begin
                commit_we  = 1'b1;
                commit_len = FULL;
                state_d    = DONE;
            end
        end
        // Standby aborts silently; a REC abort keeps everything written so far
        if (active && standby && !start_song) begin
            state_d    = IDLE;
            commit_we  = state_q == REC;
            commit_len = offset_d;
        end
        if (start_song && state_q != DONE) begin
            commit_we  = state_q == REC;
            commit_len = offset_q;
            slot_d     = song_choice;
            offset_d   = '0;
            state_d    = record_mode ? ((song_choice >= RO_SLOT_LIMIT) ? REC : DONE)
                                     : ((len_new == '0) ? DONE : PLAY);
        end
        busy_d    = state_d inside {PLAY, REC};
        done_d    = state_q == DONE;
        re_pipe_d = RD_LAT'({re_pipe_q, re_q});
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            offset_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            re_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            offset_q  <= offset_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            re_pipe_q <= re_pipe_d;
        end
    end
    assign mem.addr    = addr_q;
    assign mem.re      = re_q;
    assign mem.we      = we_q;
    assign mem.wdata   = wdata_q;
    assign play_valid  = re_pipe_q[RD_LAT-1];
    assign play_sample = play_valid ? mem.rdata : '0;
    assign song_done   = done_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_song_mem_ctrl.sv
// tb_song_mem_ctrl: directed bench for song_mem_ctrl with a two-stage read memory model
module tb_song_mem_ctrl;
    localparam int SLOT_W = 4;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = 4 + SLOT_W;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] song_choice = '0;
    logic start_song = 1'b0, pause_song = 1'b0, record_mode = 1'b0, sample_tick = 1'b0;
    logic [1:0] cfsm_state = 2'b00;
    logic [DATA_W-1:0] rec_sample = '0;
    logic [DATA_W-1:0] play_sample;
    logic play_valid, song_done, busy;
    int errors = 0, checks = 0;
    int start_cyc;
    song_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();
    song_mem_ctrl #(.SLOT_W(SLOT_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .song_choice (song_choice),
        .start_song  (start_song),
        .pause_song  (pause_song),
        .record_mode (record_mode),
        .cfsm_state  (cfsm_state),
        .sample_tick (sample_tick),
        .rec_sample  (rec_sample),
        .mem         (m),
        .play_sample (play_sample),
        .play_valid  (play_valid),
        .song_done   (song_done),
        .busy        (busy)
    );
    always #5 clk = ~clk;
    // Preloaded slots return addr^0x5A; user slots return what was written
    logic [7:0] wmem [256];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        if (m.we) wmem[m.addr] <= m.wdata;
        rd1 <= m.addr[7] ? wmem[m.addr] : (m.addr ^ 8'h5A);
        rd2 <= rd1;
    end
    assign m.rdata = rd2;
    int cyc = 0;
    int re_cyc[$], done_cyc[$], pv_cyc[$];
    logic [7:0] re_addr[$], we_addr[$], we_data[$], pv_data[$];
    always @(negedge clk) begin
        cyc++;
        if (m.re) begin re_cyc.push_back(cyc); re_addr.push_back(m.addr); end
        if (m.we) begin we_addr.push_back(m.addr); we_data.push_back(m.wdata); end
        if (song_done) done_cyc.push_back(cyc);
        if (play_valid) begin pv_cyc.push_back(cyc); pv_data.push_back(play_sample); end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask
    task automatic start(input logic [3:0] ch, input logic rec);
        song_choice = ch;
        record_mode = rec;
        start_song  = 1'b1;
        start_cyc   = cyc;
        wait_n(1);
        start_song  = 1'b0;
        wait_n(1);
    endtask
    task automatic tick(input logic [7:0] s);
        rec_sample  = s;
        sample_tick = 1'b1;
        wait_n(1);
        sample_tick = 1'b0;
        wait_n(2);
    endtask
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_re"}, m.re, 0);
        chk({tag, "_we"}, m.we, 0);
        chk({tag, "_addr"}, m.addr, 0);
        chk({tag, "_wdata"}, m.wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, song_done, 0);
        chk({tag, "_pv"}, play_valid, 0);
        chk({tag, "_ps"}, play_sample, 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
    initial begin
        int rb, wb, db, pb;
        wait_n(2);
        chk_idle_outputs("reset");
        reset = 1'b1;
        cfsm_state = 2'b01;
        wait_n(2);
        // Play preloaded slot 3 to the end
        rb = re_cyc.size(); db = done_cyc.size(); pb = pv_cyc.size();
        start(4'd3, 1'b0);
        chk("play3_busy", busy, 1);
        for (int i = 0; i < 16; i++) tick(8'h00);
        chk("play3_reads", re_cyc.size() - rb, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("play3_addr%0d", i), re_addr[rb+i], 8'h30 + i);
            chk($sformatf("play3_lat%0d", i), pv_cyc[pb+i], re_cyc[rb+i] + 2);
            chk($sformatf("play3_data%0d", i), pv_data[pb+i], (8'h30 + i) ^ 8'h5A);
        end
        chk("play3_done_cnt", done_cyc.size() - db, 1);
        chk("play3_done_cyc", done_cyc[db], re_cyc[rb+15] + 1);
        chk("play3_busy_end", busy, 0);
        // Record 5 samples into slot 9, then abort through standby
        wb = we_addr.size(); db = done_cyc.size();
        start(4'd9, 1'b1);
        for (int i = 0; i < 5; i++) tick(8'hA0 + i[7:0]);
        cfsm_state = 2'b00;
        wait_n(2);
        cfsm_state = 2'b01;
        chk("rec9_writes", we_addr.size() - wb, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rec9_addr%0d", i), we_addr[wb+i], 8'h90 + i);
            chk($sformatf("rec9_data%0d", i), we_data[wb+i], 8'hA0 + i);
        end
        chk("rec9_no_done", done_cyc.size() - db, 0);
        chk("rec9_busy_abort", busy, 0);
        // Replay slot 9: exactly the five recorded samples
        rb = re_cyc.size(); db = done_cyc.size(); pb = pv_cyc.size();
        start(4'd9, 1'b0);
        for (int i = 0; i < 7; i++) tick(8'h00);
        chk("play9_reads", re_cyc.size() - rb, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("play9_addr%0d", i), re_addr[rb+i], 8'h90 + i);
            chk($sformatf("play9_data%0d", i), pv_data[pb+i], 8'hA0 + i);
        end
        chk("play9_done", done_cyc.size() - db, 1);
        // Record slot 12 until full; a 17th tick writes nothing
        wb = we_addr.size(); db = done_cyc.size();
        start(4'd12, 1'b1);
        for (int i = 0; i < 16; i++) tick(8'hC0 + i[7:0]);
        chk("rec12_writes", we_addr.size() - wb, 16);
        chk("rec12_last_addr", we_addr[wb+15], 8'hCF);
        chk("rec12_done", done_cyc.size() - db, 1);
        tick(8'hFF);
        chk("rec12_no_17th", we_addr.size() - wb, 16);
        rb = re_cyc.size();
        start(4'd12, 1'b0);
        for (int i = 0; i < 18; i++) tick(8'h00);
        chk("play12_reads", re_cyc.size() - rb, 16);
        // Record into a read-only slot
        wb = we_addr.size(); db = done_cyc.size();
        start(4'd2, 1'b1);
        tick(8'h11);
        chk("ro2_done_cnt", done_cyc.size() - db, 1);
        chk("ro2_done_cyc", done_cyc[db], start_cyc + 2);
        chk("ro2_no_we", we_addr.size() - wb, 0);
        // Play an unrecorded slot
        rb = re_cyc.size(); db = done_cyc.size();
        start(4'd14, 1'b0);
        tick(8'h00); tick(8'h00);
        chk("empty14_done", done_cyc.size() - db, 1);
        chk("empty14_no_re", re_cyc.size() - rb, 0);
        // Pause in slot 0
        rb = re_cyc.size();
        start(4'd0, 1'b0);
        tick(8'h00); tick(8'h00);
        pause_song = 1'b1;
        for (int i = 0; i < 4; i++) tick(8'h00);
        chk("pause_no_re", re_cyc.size() - rb, 2);
        chk("pause_busy", busy, 1);
        pause_song = 1'b0;
        tick(8'h00);
        chk("pause_resume_addr", re_addr[rb+2], 8'h02);
        // Restart while playing: no done, new slot begins at offset 0
        db = done_cyc.size();
        start(4'd5, 1'b0);
        chk("restart_no_done", done_cyc.size() - db, 0);
        chk("restart_busy", busy, 1);
        rb = re_cyc.size();
        tick(8'h00);
        chk("restart_addr", re_addr[rb], 8'h50);
        cfsm_state = 2'b00;
        wait_n(2);
        cfsm_state = 2'b01;
        chk("play_abort_no_done", done_cyc.size() - db, 0);
        chk("play_abort_busy", busy, 0);
        // Asynchronous reset in the middle of a recording at offset 7
        start(4'd10, 1'b1);
        for (int i = 0; i < 7; i++) tick(8'h70 + i[7:0]);
        sample_tick = 1'b1;
        @(posedge clk);
        #2;
        chk("midrec_we", m.we, 1);
        chk("midrec_addr", m.addr, 8'hA7);
        reset = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        sample_tick = 1'b0;
        wait_n(2);
        reset = 1'b1;
        wait_n(2);
        // User slots are empty again, preloaded slots still full
        for (int k = 8; k < 16; k += 3) begin
            rb = re_cyc.size(); db = done_cyc.size();
            start(k[3:0], 1'b0);
            tick(8'h00);
            chk($sformatf("post_reset_len%0d_re", k), re_cyc.size() - rb, 0);
            chk($sformatf("post_reset_len%0d_done", k), done_cyc.size() - db, 1);
        end
        rb = re_cyc.size();
        start(4'd12, 1'b0);
        tick(8'h00);
        chk("post_reset_len12_re", re_cyc.size() - rb, 0);
        start(4'd5, 1'b0);
        tick(8'h00);
        chk("post_reset_slot5_re", re_cyc.size() - rb, 1);
        cfsm_state = 2'b00;
        wait_n(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
